sap_control_sequencer: RTL and testbench

Parametrised next-generation SAP control unit. It sequences fetch/decode/execute T-states and drives the 18-bit control word to the bus, memory, registers and ALU. It extends the current instruction set with a negative-flag jump (JMPN), illegal-opcode detection, resume-from-halt and a single-step mode. It sits between the instruction register, the flag register and every datapath enable.

---
 rtl/sap_cu_pkg.sv | 69 ++++++
 rtl/sap_control_sequencer_if.sv | 26 ++
 rtl/sap_cu_decode.sv | 87 ++++++++
 rtl/sap_control_sequencer.sv | 80 ++++++++
 tb/tb_sap_control_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sap_cu_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, state codes,
// control-bit positions and the precomputed control words.
package sap_cu_pkg;

  localparam int CW_W = 18;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JMPC = 4'h6;
  localparam logic [3:0] OP_JMPZ = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_INCA = 4'h9;
  localparam logic [3:0] OP_DECR = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hC;
  localparam logic [3:0] OP_JMPN = 4'hD;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_IDLE  = 4'd1,
    ST_F1    = 4'd2,
    ST_F2    = 4'd3,
    ST_E1    = 4'd4,
    ST_E2    = 4'd5,
    ST_E3    = 4'd6,
    ST_HALT  = 4'd7,
    ST_WAIT  = 4'd8
  } state_e;

  localparam int B_PC_INC  = 0;
  localparam int B_PC_OUT  = 1;
  localparam int B_PC_LOAD = 2;
  localparam int B_MAR_IN  = 3;
  localparam int B_RAM_OUT = 4;
  localparam int B_RAM_IN  = 5;
  localparam int B_IR_IN   = 6;
  localparam int B_IR_OUT  = 7;
  localparam int B_A_IN    = 8;
  localparam int B_A_OUT   = 9;
  localparam int B_B_IN    = 10;
  localparam int B_ALU_OUT = 11;
  localparam int B_ALU_SUB = 12;
  localparam int B_ALU_INC = 13;
  localparam int B_ALU_DEC = 14;
  localparam int B_OUT_IN  = 15;
  localparam int B_FLAG_IN = 16;
  localparam int B_HALT    = 17;

  function automatic logic [CW_W-1:0] cb(input int idx);
    return CW_W'(1) << idx;
  endfunction

  localparam logic [CW_W-1:0] CW_FETCH1  = cb(B_PC_OUT)  | cb(B_MAR_IN);
  localparam logic [CW_W-1:0] CW_FETCH2  = cb(B_RAM_OUT) | cb(B_IR_IN) | cb(B_PC_INC);
  localparam logic [CW_W-1:0] CW_ADDR    = cb(B_IR_OUT)  | cb(B_MAR_IN);
  localparam logic [CW_W-1:0] CW_LOAD_A  = cb(B_RAM_OUT) | cb(B_A_IN);
  localparam logic [CW_W-1:0] CW_STORE_A = cb(B_A_OUT)   | cb(B_RAM_IN);
  localparam logic [CW_W-1:0] CW_LOAD_B  = cb(B_RAM_OUT) | cb(B_B_IN);
  localparam logic [CW_W-1:0] CW_ALU_A   = cb(B_ALU_OUT) | cb(B_A_IN) | cb(B_FLAG_IN);
  localparam logic [CW_W-1:0] CW_JUMP    = cb(B_IR_OUT)  | cb(B_PC_LOAD);
  localparam logic [CW_W-1:0] CW_LDI     = cb(B_IR_OUT)  | cb(B_A_IN);
  localparam logic [CW_W-1:0] CW_OUT     = cb(B_A_OUT)   | cb(B_OUT_IN);
  localparam logic [CW_W-1:0] CW_HALT    = cb(B_HALT);

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Sequencer-facing signals: instruction/flag inputs, mode controls and the
// control word with its status outputs.
interface sap_control_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int FLAG_W   = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic [FLAG_W-1:0]   flag_reg;
  logic                step_en;
  logic                step_req;
  logic                resume;
  logic [17:0]         ctrl_word;
  logic [3:0]          tstate;
  logic                halted;
  logic                illegal;

  modport master (
    output opcode, flag_reg, step_en, step_req, resume,
    input  ctrl_word, tstate, halted, illegal
  );

  modport slave (
    input  opcode, flag_reg, step_en, step_req, resume,
    output ctrl_word, tstate, halted, illegal
  );
endinterface

// File: rtl/sap_cu_decode.sv
// Combinational decode: (state, opcode, flags) -> control word, end-of-
// instruction marker and illegal-opcode pulse.
module sap_cu_decode
  import sap_cu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FLAG_W   = 3,
  parameter int CF_BIT   = 0,
  parameter int ZF_BIT   = 1,
  parameter int NF_BIT   = 2
) (
  input  state_e              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [FLAG_W-1:0]   flags_i,
  output logic [CW_W-1:0]     ctrl_word_o,
  output logic                last_o,
  output logic                illegal_o
);

  logic       illegal_op;
  logic [3:0] op4;

  // Anything above JMPN, including any set bit above bit 3, is illegal.
  assign illegal_op = (opcode_i > OPCODE_W'(OP_JMPN));
  assign op4        = opcode_i[3:0];
  assign illegal_o  = (state_i == ST_F2) && illegal_op;

  always_comb begin
    ctrl_word_o = '0;
    last_o      = 1'b0;
    case (state_i)
      ST_F1: ctrl_word_o = CW_FETCH1;
      ST_F2: begin
        ctrl_word_o = CW_FETCH2;
        last_o      = illegal_op || (op4 == OP_NOP);
      end
      ST_E1: begin
        last_o = 1'b1;
        case (op4)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
            ctrl_word_o = CW_ADDR;
            last_o      = 1'b0;
          end
          OP_INCA: begin
            ctrl_word_o = cb(B_ALU_INC);
            last_o      = 1'b0;
          end
          OP_DECR: begin
            ctrl_word_o = cb(B_ALU_DEC);
            last_o      = 1'b0;
          end
          OP_JMP:  ctrl_word_o = CW_JUMP;
          OP_JMPZ: ctrl_word_o = flags_i[ZF_BIT] ? CW_JUMP : '0;
          OP_JMPC: ctrl_word_o = flags_i[CF_BIT] ? CW_JUMP : '0;
          OP_JMPN: ctrl_word_o = flags_i[NF_BIT] ? CW_JUMP : '0;
          OP_LDI:  ctrl_word_o = CW_LDI;
          OP_OUT:  ctrl_word_o = CW_OUT;
          default: ;
        endcase
      end
      ST_E2: begin
        last_o = 1'b1;
        case (op4)
          OP_LDA:          ctrl_word_o = CW_LOAD_A;
          OP_STA:          ctrl_word_o = CW_STORE_A;
          OP_ADD, OP_SUB: begin
            ctrl_word_o = CW_LOAD_B;
            last_o      = 1'b0;
          end
          OP_INCA, OP_DECR: ctrl_word_o = CW_ALU_A;
          default: ;
        endcase
      end
      ST_E3: begin
        last_o = 1'b1;
        case (op4)
          OP_ADD:  ctrl_word_o = CW_ALU_A;
          OP_SUB:  ctrl_word_o = CW_ALU_A | cb(B_ALU_SUB);
          default: ;
        endcase
      end
      ST_HALT: ctrl_word_o = CW_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: falling-edge T-state register with step/halt
// handling; the control word is decoded combinationally from the state.
module sap_control_sequencer
  import sap_cu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FLAG_W   = 3,
  parameter int CF_BIT   = 0,
  parameter int ZF_BIT   = 1,
  parameter int NF_BIT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  sap_control_sequencer_if.slave  bus
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q;
  logic [OPCODE_W-1:0] op_eff;
  logic [CW_W-1:0]     ctrl_word;
  logic                last_state;
  logic                illegal;
  state_e              boundary;

  // The opcode is taken live in F2 and held for the execute states, so
  // later IR changes cannot disturb an instruction already in flight.
  assign op_eff   = (state_q == ST_F2) ? bus.opcode : opc_q;
  assign boundary = bus.step_en ? ST_WAIT : ST_F1;

  sap_cu_decode #(
    .OPCODE_W (OPCODE_W),
    .FLAG_W   (FLAG_W),
    .CF_BIT   (CF_BIT),
    .ZF_BIT   (ZF_BIT),
    .NF_BIT   (NF_BIT)
  ) u_decode (
    .state_i     (state_q),
    .opcode_i    (op_eff),
    .flags_i     (bus.flag_reg),
    .ctrl_word_o (ctrl_word),
    .last_o      (last_state),
    .illegal_o   (illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  state_d = ST_F1;
      ST_F1:    state_d = ST_F2;
      ST_F2: begin
        if (bus.opcode == OPCODE_W'(OP_HLT)) state_d = ST_HALT;
        else if (last_state)                 state_d = boundary;
        else                                 state_d = ST_E1;
      end
      ST_E1:    state_d = last_state ? boundary : ST_E2;
      ST_E2:    state_d = last_state ? boundary : ST_E3;
      ST_E3:    state_d = boundary;
      ST_HALT:  state_d = bus.resume ? ST_F1 : ST_HALT;
      ST_WAIT:  state_d = bus.step_req ? ST_F1 : ST_WAIT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_F2) opc_q <= bus.opcode;
    end
  end

  assign bus.ctrl_word = ctrl_word;
  assign bus.tstate    = state_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: samples 1ns after each rising
// edge, midway between the falling edges that move the state.
module tb_sap_control_sequencer;
  import sap_cu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sap_control_sequencer_if #(.OPCODE_W(4), .FLAG_W(3)) bus ();

  sap_control_sequencer #(
    .OPCODE_W(4), .FLAG_W(3), .CF_BIT(0), .ZF_BIT(1), .NF_BIT(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.opcode = OP_LDA; bus.flag_reg = '0;
    bus.step_en = 1'b0; bus.step_req = 1'b0; bus.resume = 1'b0;
    #3 rst = 1'b1;
    #5;
    checks++;
    if (bus.tstate !== 4'd0 || bus.ctrl_word !== 18'h0 || bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset: tstate=%0d ctrl=%h halted=%b illegal=%b exp 0/0/0/0",
               bus.tstate, bus.ctrl_word, bus.halted, bus.illegal);
    end
    #4 rst = 1'b0;
  endtask

  task automatic test_lda();
    logic [3:0]  exp_t [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd2};
    logic [17:0] exp_c [7] = '{18'h0, 18'h0, 18'h0000A, 18'h00051, 18'h00088, 18'h00110, 18'h0000A};
    for (int i = 0; i < 7; i++) begin
      nxt();
      checks++;
      if (bus.tstate !== exp_t[i] || bus.ctrl_word !== exp_c[i]) begin
        failures++;
        $display("FAIL lda step %0d: tstate=%0d ctrl=%h exp %0d/%h",
                 i, bus.tstate, bus.ctrl_word, exp_t[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [3:0]  ops [2]   = '{OP_ADD, OP_SUB};
    logic [17:0] e3 [2]    = '{18'h10900, 18'h11900};
    logic [3:0]  exp_t [5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd2};
    logic [17:0] exp_c [5];
    for (int k = 0; k < 2; k++) begin
      bus.opcode = ops[k];
      exp_c = '{18'h00051, 18'h00088, 18'h00410, e3[k], 18'h0000A};
      for (int i = 0; i < 5; i++) begin
        nxt();
        checks++;
        if (bus.tstate !== exp_t[i] || bus.ctrl_word !== exp_c[i]) begin
          failures++;
          $display("FAIL add_sub op=%h step %0d: tstate=%0d ctrl=%h exp %0d/%h",
                   ops[k], i, bus.tstate, bus.ctrl_word, exp_t[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_jumps();
    logic [3:0]  ops [5] = '{OP_JMPZ, OP_JMPZ, OP_JMPC, OP_JMPN, OP_JMPN};
    logic [2:0]  fl  [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b011};
    logic [17:0] e1  [5] = '{18'h0, 18'h84, 18'h84, 18'h84, 18'h0};
    for (int k = 0; k < 5; k++) begin
      bus.opcode = ops[k]; bus.flag_reg = fl[k];
      nxt();
      nxt();
      checks++;
      if (bus.tstate !== 4'd4 || bus.ctrl_word !== e1[k]) begin
        failures++;
        $display("FAIL jump %0d E1: tstate=%0d ctrl=%h exp 4/%h", k, bus.tstate, bus.ctrl_word, e1[k]);
      end
      nxt();
      checks++;
      if (bus.tstate !== 4'd2) begin
        failures++;
        $display("FAIL jump %0d return: tstate=%0d exp 2", k, bus.tstate);
      end
    end
    bus.flag_reg = '0;
  endtask

  task automatic test_misc_ops();
    logic [3:0]  ops [6] = '{OP_STA, OP_INCA, OP_DECR, OP_LDI, OP_OUT, OP_JMP};
    int          len [6] = '{2, 2, 2, 1, 1, 1};
    logic [17:0] e1  [6] = '{18'h00088, 18'h02000, 18'h04000, 18'h00180, 18'h08200, 18'h00084};
    logic [17:0] e2  [6] = '{18'h00220, 18'h10900, 18'h10900, 18'h0, 18'h0, 18'h0};
    for (int k = 0; k < 6; k++) begin
      bus.opcode = ops[k];
      nxt();
      nxt();
      checks++;
      if (bus.tstate !== 4'd4 || bus.ctrl_word !== e1[k]) begin
        failures++;
        $display("FAIL op %h E1: tstate=%0d ctrl=%h exp 4/%h", ops[k], bus.tstate, bus.ctrl_word, e1[k]);
      end
      if (len[k] == 2) begin
        nxt();
        checks++;
        if (bus.tstate !== 4'd5 || bus.ctrl_word !== e2[k]) begin
          failures++;
          $display("FAIL op %h E2: tstate=%0d ctrl=%h exp 5/%h", ops[k], bus.tstate, bus.ctrl_word, e2[k]);
        end
      end
      nxt();
      checks++;
      if (bus.tstate !== 4'd2) begin
        failures++;
        $display("FAIL op %h return: tstate=%0d exp 2", ops[k], bus.tstate);
      end
    end
  endtask

  task automatic test_illegal();
    bus.opcode = 4'hF;
    checks++;
    if (bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal in F1: got %b exp 0", bus.illegal);
    end
    nxt();
    checks++;
    if (bus.tstate !== 4'd3 || bus.illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal F2: tstate=%0d illegal=%b exp 3/1", bus.tstate, bus.illegal);
    end
    nxt();
    checks++;
    if (bus.tstate !== 4'd2 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal after: tstate=%0d illegal=%b exp 2/0", bus.tstate, bus.illegal);
    end
  endtask

  task automatic test_halt();
    bus.opcode = OP_HLT;
    nxt();
    for (int i = 0; i < 5; i++) begin
      nxt();
      checks++;
      if (bus.tstate !== 4'd7 || bus.halted !== 1'b1 || bus.ctrl_word !== 18'h20000) begin
        failures++;
        $display("FAIL halt cycle %0d: tstate=%0d halted=%b ctrl=%h exp 7/1/20000",
                 i, bus.tstate, bus.halted, bus.ctrl_word);
      end
    end
    bus.resume = 1'b1;
    nxt();
    bus.resume = 1'b0;
    checks++;
    if (bus.tstate !== 4'd2 || bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL resume: tstate=%0d halted=%b exp 2/0", bus.tstate, bus.halted);
    end
  endtask

  task automatic test_step();
    logic [3:0] exp_t [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd8};
    bus.step_en = 1'b1;
    bus.opcode  = OP_NOP;
    nxt();
    for (int i = 0; i < 3; i++) begin
      nxt();
      checks++;
      if (bus.tstate !== 4'd8 || bus.ctrl_word !== 18'h0) begin
        failures++;
        $display("FAIL step wait %0d: tstate=%0d ctrl=%h exp 8/0", i, bus.tstate, bus.ctrl_word);
      end
    end
    bus.opcode   = OP_LDA;
    bus.step_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      bus.step_req = 1'b0;
      checks++;
      if (bus.tstate !== exp_t[i]) begin
        failures++;
        $display("FAIL step run %0d: tstate=%0d exp %0d", i, bus.tstate, exp_t[i]);
      end
    end
    // Second stepped instruction, aborted by reset during E2.
    bus.step_req = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    bus.step_req = 1'b0;
    checks++;
    if (bus.tstate !== 4'd5 || bus.ctrl_word !== 18'h00110) begin
      failures++;
      $display("FAIL step E2: tstate=%0d ctrl=%h exp 5/00110", bus.tstate, bus.ctrl_word);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.tstate !== 4'd0 || bus.ctrl_word !== 18'h0) begin
      failures++;
      $display("FAIL reset in E2: tstate=%0d ctrl=%h exp 0/0", bus.tstate, bus.ctrl_word);
    end
    #2 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_jumps();
    test_misc_ops();
    test_illegal();
    test_halt();
    test_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
